// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings for the unified memory arbiter: mode states, read-owner tags
// and the default bus widths used by pipelinedPS.
package unified_mem_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 16;

    localparam logic [1:0] S_HOST  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_IM   = 2'd2,
        OWN_DM   = 2'd3
    } owner_t;

endpackage

// File: rtl/unified_mem_arbiter_arb_prio2.sv
// Two-way dm/im priority picker: data port wins by default, but fetch takes one
// grant after MAX_WAIT consecutive denied cycles.
module arb_prio2
    import unified_mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic dm_req,
    input  logic im_req,
    output logic dm_win,
    output logic im_win
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0] wait_cnt;
    logic          starved;

    always_comb begin
        starved = (wait_cnt == WW'(MAX_WAIT));
        im_win  = enable & im_req & (starved | ~dm_req);
        dm_win  = enable & dm_req & ~im_win;
    end

    // Counter never passes MAX_WAIT: reaching it forces an im grant, which clears it.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            wait_cnt <= '0;
        end else if (im_win) begin
            wait_cnt <= '0;
        end else if (im_req) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous memory between the host loader and the
// pipelinedPS fetch/data ports, and sequences host -> CPU -> drain -> host ownership.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_WAIT   = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    output logic                  cpu_start,
    input  logic                  cpu_stop,
    output logic                  busy,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    input  logic                  im_rd,
    input  logic [ADDR_WIDTH-1:0] im_addr,
    output logic                  im_gnt,
    output logic                  im_rvalid,
    output logic [DATA_WIDTH-1:0] im_rdata,
    input  logic                  dm_rd,
    input  logic                  dm_wr,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    owner_t                owner_q;
    owner_t                owner_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  run;
    logic                  dm_win;
    logic                  im_win;

    assign run  = (state == S_RUN);
    assign busy = (state != S_HOST);

    arb_prio2 #(
        .MAX_WAIT(MAX_WAIT)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .enable (run),
        .dm_req (dm_rd | dm_wr),
        .im_req (im_rd),
        .dm_win (dm_win),
        .im_win (im_win)
    );

    // Grant decode and memory mux; an idle cycle replays the last address/data.
    always_comb begin
        host_gnt  = (state == S_HOST) & host_req;
        dm_gnt    = dm_win;
        im_gnt    = im_win;
        mem_en    = host_gnt | dm_gnt | im_gnt;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        owner_nxt = OWN_NONE;
        if (host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            owner_nxt = host_we ? OWN_NONE : OWN_HOST;
        end else if (dm_gnt) begin
            mem_we    = dm_wr;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            owner_nxt = dm_wr ? OWN_NONE : OWN_DM;
        end else if (im_gnt) begin
            mem_addr  = im_addr;
            owner_nxt = OWN_IM;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HOST:  if (go) state_nxt = S_RUN;
            S_RUN:   if (cpu_stop) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_HOST;
            default: state_nxt = S_HOST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_HOST;
            owner_q      <= OWN_NONE;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_start    <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner_q   <= owner_nxt;
            addr_q    <= mem_addr;
            wdata_q   <= mem_wdata;
            cpu_start <= (state == S_HOST) & go;
            if (im_rd && !im_gnt && dm_gnt && !(&conflict_cnt)) begin
                conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Read returns are masked while rst is high so a reset cancels the pending data.
    always_comb begin
        host_rvalid = (owner_q == OWN_HOST) & ~rst;
        im_rvalid   = (owner_q == OWN_IM) & ~rst;
        dm_rvalid   = (owner_q == OWN_DM) & ~rst;
        host_rdata  = host_rvalid ? mem_rdata : '0;
        im_rdata    = im_rvalid ? mem_rdata : '0;
        dm_rdata    = dm_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: stimulus pushes expected read data into
// per-port queues, a monitor pops them whenever an rvalid appears.
module tb_unified_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        go;
    logic        cpu_start;
    logic        cpu_stop;
    logic        busy;
    logic        host_req;
    logic        host_we;
    logic [7:0]  host_addr;
    logic [15:0] host_wdata;
    logic        host_gnt;
    logic        host_rvalid;
    logic [15:0] host_rdata;
    logic        im_rd;
    logic [7:0]  im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [15:0] im_rdata;
    logic        dm_rd;
    logic        dm_wr;
    logic [7:0]  dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [15:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] conflict_cnt;

    logic [15:0] mem [256];
    logic [15:0] host_q [$];
    logic [15:0] im_q [$];
    logic [15:0] dm_q [$];
    int          checks;
    int          errors;

    unified_mem_arbiter #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(16),
        .MAX_WAIT  (4),
        .CNT_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .cpu_start    (cpu_start),
        .cpu_stop     (cpu_stop),
        .busy         (busy),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_gnt     (host_gnt),
        .host_rvalid  (host_rvalid),
        .host_rdata   (host_rdata),
        .im_rd        (im_rd),
        .im_addr      (im_addr),
        .im_gnt       (im_gnt),
        .im_rvalid    (im_rvalid),
        .im_rdata     (im_rdata),
        .dm_rd        (dm_rd),
        .dm_wr        (dm_wr),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_gnt       (dm_gnt),
        .dm_rvalid    (dm_rvalid),
        .dm_rdata     (dm_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous memory; reset preloads mem[i] = 16'hA000 + i.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 + 16'(i);
            mem_rdata <= 16'h0000;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs just after the falling edge, then settles.
    task automatic applyStimulus(
        input logic r, input logic g, input logic stop,
        input logic hreq, input logic hwe, input logic [7:0] haddr, input logic [15:0] hwd,
        input logic imr, input logic [7:0] ima,
        input logic dmr, input logic dmw, input logic [7:0] dma, input logic [15:0] dmwd);
        @(negedge clk);
        rst        = r;
        go         = g;
        cpu_stop   = stop;
        host_req   = hreq;
        host_we    = hwe;
        host_addr  = haddr;
        host_wdata = hwd;
        im_rd      = imr;
        im_addr    = ima;
        dm_rd      = dmr;
        dm_wr      = dmw;
        dm_addr    = dma;
        dm_wdata   = dmwd;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 16'h0);
    endtask

    // Scoreboard monitor: every rvalid must match the oldest expected value for that port.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (host_rvalid) begin
                checks++;
                if (host_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL host_rvalid_unexpected actual=1 expected=0 t=%0t", $time);
                end else begin
                    logic [15:0] e;
                    e = host_q.pop_front();
                    if (host_rdata !== e) begin
                        errors++;
                        $display("[TB] FAIL host_rdata actual=%0h expected=%0h t=%0t", host_rdata, e, $time);
                    end
                end
            end
            if (im_rvalid) begin
                checks++;
                if (im_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL im_rvalid_unexpected actual=1 expected=0 t=%0t", $time);
                end else begin
                    logic [15:0] e;
                    e = im_q.pop_front();
                    if (im_rdata !== e) begin
                        errors++;
                        $display("[TB] FAIL im_rdata actual=%0h expected=%0h t=%0t", im_rdata, e, $time);
                    end
                end
            end
            if (dm_rvalid) begin
                checks++;
                if (dm_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL dm_rvalid_unexpected actual=1 expected=0 t=%0t", $time);
                end else begin
                    logic [15:0] e;
                    e = dm_q.pop_front();
                    if (dm_rdata !== e) begin
                        errors++;
                        $display("[TB] FAIL dm_rdata actual=%0h expected=%0h t=%0t", dm_rdata, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        logic exp_im;
        checks = 0;
        errors = 0;
        rst = 1'b1; go = 1'b0; cpu_stop = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 8'd0; host_wdata = 16'h0;
        im_rd = 1'b0; im_addr = 8'd0; dm_rd = 1'b0; dm_wr = 1'b0; dm_addr = 8'd0; dm_wdata = 16'h0;
        repeat (3) @(posedge clk);

        idleCycle();
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_cpu_start", 32'(cpu_start), 0);
        checkOutput("reset_conflict_cnt", 32'(conflict_cnt), 0);
        checkOutput("reset_mem_en", 32'(mem_en), 0);
        checkOutput("reset_rvalids", 32'({host_rvalid, im_rvalid, dm_rvalid}), 0);

        // Host load: write 7 to addr 12 and read it back while fetch is held off.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd12, 16'h0007, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 16'h0);
        checkOutput("host_wr_gnt", 32'(host_gnt), 1);
        checkOutput("host_wr_im_gnt", 32'(im_gnt), 0);
        checkOutput("host_wr_mem_we", 32'(mem_we), 1);
        checkOutput("host_wr_mem_addr", 32'(mem_addr), 12);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd12, 16'h0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 16'h0);
        checkOutput("host_rd_gnt", 32'(host_gnt), 1);
        checkOutput("host_rd_im_gnt", 32'(im_gnt), 0);
        checkOutput("host_rd_mem_we", 32'(mem_we), 0);
        host_q.push_back(16'h0007);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 16'h0);
        checkOutput("host_idle_im_gnt", 32'(im_gnt), 0);
        checkOutput("host_idle_mem_en", 32'(mem_en), 0);
        checkOutput("host_idle_addr_hold", 32'(mem_addr), 12);
        checkOutput("host_idle_conflict", 32'(conflict_cnt), 0);

        // Start sequencing: go at T, CPU owns memory from T+1.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 16'h0);
        checkOutput("go_busy_T", 32'(busy), 0);
        checkOutput("go_cpu_start_T", 32'(cpu_start), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 16'h0);
        checkOutput("go_busy_T1", 32'(busy), 1);
        checkOutput("go_cpu_start_T1", 32'(cpu_start), 1);
        checkOutput("go_im_gnt_T1", 32'(im_gnt), 1);
        im_q.push_back(16'hA000);
        idleCycle();
        checkOutput("go_cpu_start_T2", 32'(cpu_start), 0);
        checkOutput("go_im_rvalid_T2", 32'(im_rvalid), 1);

        // Priority: dm beats im, then im is served next.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 8'd1, 1'b1, 1'b0, 8'd2, 16'h0);
        checkOutput("prio_dm_gnt", 32'(dm_gnt), 1);
        checkOutput("prio_im_gnt", 32'(im_gnt), 0);
        checkOutput("prio_mem_addr", 32'(mem_addr), 2);
        dm_q.push_back(16'hA002);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 8'd1, 1'b0, 1'b0, 8'd0, 16'h0);
        checkOutput("prio_next_im_gnt", 32'(im_gnt), 1);
        checkOutput("prio_conflict_cnt", 32'(conflict_cnt), 1);
        im_q.push_back(16'hA001);

        // Starvation: continuous dm writes vs fetch, expected dm x4, im, dm x4, im.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 8'd3, 1'b0, 1'b1, 8'd20, 16'h1234);
            exp_im = (i == 4) || (i == 9);
            checkOutput("starve_im_gnt", 32'(im_gnt), 32'(exp_im));
            checkOutput("starve_dm_gnt", 32'(dm_gnt), 32'(!exp_im));
            if (exp_im) im_q.push_back(16'hA003);
        end

        // Stop with a dm read in the same cycle; data returns during drain.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd12, 16'h0);
        checkOutput("stop_dm_gnt", 32'(dm_gnt), 1);
        checkOutput("stop_conflict_cnt", 32'(conflict_cnt), 9);
        dm_q.push_back(16'h0007);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 8'd0, 1'b1, 1'b0, 8'd12, 16'h0);
        checkOutput("drain_busy", 32'(busy), 1);
        checkOutput("drain_no_gnt", 32'({dm_gnt, im_gnt, host_gnt}), 0);
        checkOutput("drain_mem_en", 32'(mem_en), 0);
        checkOutput("drain_dm_rvalid", 32'(dm_rvalid), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd12, 16'h0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 16'h0);
        checkOutput("back_host_busy", 32'(busy), 0);
        checkOutput("back_host_gnt", 32'(host_gnt), 1);
        host_q.push_back(16'h0007);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd20, 16'h0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 16'h0);
        checkOutput("back_host_gnt2", 32'(host_gnt), 1);
        host_q.push_back(16'h1234);

        // Reset while an im read return is pending: the return must be dropped.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 16'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 8'd5, 1'b0, 1'b0, 8'd0, 16'h0);
        checkOutput("rst_pre_im_gnt", 32'(im_gnt), 1);
        checkOutput("rst_pre_cpu_start", 32'(cpu_start), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 16'h0);
        checkOutput("rst_im_rvalid", 32'(im_rvalid), 0);
        idleCycle();
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_conflict_cnt", 32'(conflict_cnt), 0);
        checkOutput("rst_cpu_start", 32'(cpu_start), 0);
        checkOutput("rst_im_rvalid_after", 32'(im_rvalid), 0);
        repeat (2) idleCycle();

        checkOutput("host_q_drained", 32'(host_q.size()), 0);
        checkOutput("im_q_drained", 32'(im_q.size()), 0);
        checkOutput("dm_q_drained", 32'(dm_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port 256x16 synchronous memory between three requesters:
  - host loader port;
  - pipelinedPS instruction-fetch port;
  - pipelinedPS data port.
- Sequences processor bring-up: the host owns memory until `go`, then the CPU owns it until `cpu_stop`, then the block drains and returns ownership to the host.
- In CPU mode the data port has priority over fetch, with an anti-starvation override for fetch.

Parameters:
- ADDR_WIDTH, 8, memory/port address width
- DATA_WIDTH, 16, memory/port data width
- MAX_WAIT, 4, consecutive denied fetch cycles before fetch gets one priority grant
- CNT_WIDTH, 16, width of the fetch-conflict statistics counter

Ports:
- clk  in  1  clock
- rst  in  1  reset
- go  in  1  host hands memory to CPU (sampled only in S_HOST)
- cpu_start  out  1  one-cycle start pulse to processor
- cpu_stop  in  1  processor stop indication
- busy  out  1  high when state != S_HOST
- host_req  in  1  host access request
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_WIDTH  host address
- host_wdata  in  DATA_WIDTH  host write data
- host_gnt  out  1  host request accepted this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_WIDTH  host read data
- im_rd  in  1  fetch request
- im_addr  in  ADDR_WIDTH  fetch address
- im_gnt  out  1  fetch accepted
- im_rvalid  out  1  fetch data valid
- im_rdata  out  DATA_WIDTH  fetch data
- dm_rd  in  1  data read request
- dm_wr  in  1  data write request
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  data write data
- dm_gnt  out  1  data access accepted
- dm_rvalid  out  1  data read valid
- dm_rdata  out  DATA_WIDTH  data read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_en & !mem_we
- conflict_cnt  out  CNT_WIDTH  saturating count of cycles fetch was denied because of data port

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values:
  - state = S_HOST.
  - All gnt, rvalid, mem_en, mem_we and cpu_start = 0.
  - Wait counter = 0, conflict_cnt = 0, read-owner tag cleared.
  - rst mid-transaction drops any pending rvalid.
- Request/grant protocol:
  - A requester holds its request and address/data until it sees gnt.
  - gnt is combinational in the request cycle; the memory command is driven in the same cycle.
  - At most one gnt per cycle.
- Read return:
  - The owner tag is registered at grant.
  - X_rvalid = 1 exactly one cycle after a read grant; X_rdata = mem_rdata.
  - rdata ports are valid only while rvalid is high.
  - Writes produce no rvalid.
- S_HOST:
  - Only the host is served: host_gnt = host_req.
  - im/dm are never granted.
  - go = 1 → S_RUN; cpu_start = 1 in the following cycle only.
  - cpu_stop is ignored in this state.
- S_RUN:
  - The host is never granted.
  - Default priority is dm > im.
  - If dm_rd and dm_wr are both high, the write wins and is the only access performed.
  - Anti-starvation:
    - The wait counter increments each cycle im_rd = 1 and im_gnt = 0; it clears on im_gnt.
    - When the counter == MAX_WAIT, im wins over dm in that cycle and the counter clears.
  - conflict_cnt increments, saturating at all-ones, each cycle im_rd = 1 & im_gnt = 0 & dm granted.
  - cpu_stop = 1 → S_DRAIN. A request in the same cycle as cpu_stop is still arbitrated and granted normally.
  - go is ignored in this state.
- S_DRAIN:
  - No new grants.
  - Any outstanding rvalid completes this cycle.
  - Next cycle → S_HOST.
- Status: busy = 1 in S_RUN and S_DRAIN.
- Idle memory interface: when no grant, mem_en = 0, mem_we = 0, and mem_addr/mem_wdata hold their last value.

Decomposition:
- Shared package holds:
  - state encoding S_HOST / S_RUN / S_DRAIN;
  - owner tag encoding OWN_NONE / OWN_HOST / OWN_IM / OWN_DM;
  - default widths ADDR_WIDTH and DATA_WIDTH, matching pipelinedPS.
- One natural sub-module, arb_prio2: a dm/im priority picker containing the wait counter and the MAX_WAIT override.
- Mode FSM, memory mux and read-return tag stay in the top.

Test Plan:
- Host load:
  - Stimulus: in S_HOST, host writes 16'h0007 to addr 12, then reads addr 12.
  - Required: host_gnt on both accesses; host_rvalid one cycle after the read grant with host_rdata = 16'h0007; im_rd held high is never granted.
- Start sequencing:
  - Stimulus: go pulse at cycle T.
  - Required: busy = 1 from T+1; cpu_start = 1 at T+1 only; im_rd at addr 0 granted at T+1 with im_rvalid at T+2.
- Priority:
  - Stimulus: im_rd and dm_rd asserted together for one cycle.
  - Required: dm_gnt = 1, im_gnt = 0, conflict_cnt += 1; next cycle im granted.
- Starvation:
  - Stimulus: dm_wr and im_rd held continuously.
  - Required: grant pattern is dm ×4, im, dm ×4, im; conflict_cnt = 8 after 10 cycles.
- Stop/drain:
  - Stimulus: dm_rd to addr 12 granted in the same cycle as cpu_stop.
  - Required: dm_rvalid = 1 next cycle (S_DRAIN) with the value read from addr 12; state = S_HOST after that; the host can read addr 12.
- Reset mid-read:
  - Stimulus: rst asserted in the cycle after an im read grant.
  - Required: im_rvalid = 0; state = S_HOST; conflict_cnt = 0; cpu_start = 0.
